disp_scheduler: RTL and testbench

Time-shares the single 4-digit seven-segment display between up to NUM_SRC 32-bit requesters, such as the instruction, PC, ALU result and a register readout. Each selected word is shown in two phases: upper half, then lower half. It drives the display driver's 32-bit word and lower_bytes select. Phases advance automatically on a dwell timer, or manually on a debounced push-button. The block sits between the CPU debug taps and the display driver in the board top level.

---
 rtl/disp_scheduler_if.sv | 28 ++
 rtl/disp_scheduler.sv | 154 +++++++++++++++
 tb/tb_disp_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/disp_scheduler_if.sv
// Bundle of the requester inputs and display-driver outputs of disp_scheduler.
// The slave modport is the scheduler; the master modport is the board/CPU side.
interface disp_scheduler_if #(
    parameter int NUM_SRC = 4
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [32*NUM_SRC-1:0] src_word;
    logic [NUM_SRC-1:0]    src_valid;
    logic                  btn_next;
    logic                  auto_mode;
    logic                  hold;
    logic [31:0]           disp_word;
    logic                  lower_bytes;
    logic [SW-1:0]         src_sel;
    logic                  blank;
    logic [1:0]            dbg_state;

    modport master (
        output src_word, src_valid, btn_next, auto_mode, hold,
        input  disp_word, lower_bytes, src_sel, blank, dbg_state
    );

    modport slave (
        input  src_word, src_valid, btn_next, auto_mode, hold,
        output disp_word, lower_bytes, src_sel, blank, dbg_state
    );
endinterface

// File: rtl/disp_scheduler.sv
// Round-robin time-sharing of a 4-digit display between NUM_SRC 32-bit words,
// each shown as upper half then lower half, advanced by dwell timer or button.
module disp_scheduler #(
    parameter int NUM_SRC         = 4,
    parameter int DWELL_CYCLES    = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    disp_scheduler_if.slave   bus
);
    localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int DWW = $clog2(DWELL_CYCLES);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHOW_UPPER = 2'd1,
        SHOW_LOWER = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  src_sel_q, src_sel_d;
    logic [31:0]    disp_word_q;
    logic           lower_q;
    logic           blank_q;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic           load;

    logic           sync1_q, sync2_q, stable_q, stable_prev_q;
    logic [DBW-1:0] deb_cnt_q;
    logic           btn_rise;
    logic           adv;
    logic           changed;
    logic [SW-1:0]  nxt_sel;

    // Stable level follows the synchronised button only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            deb_cnt_q     <= '0;
        end else begin
            sync1_q       <= bus.btn_next;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            if (sync2_q != stable_q) begin
                if (deb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q  <= sync2_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 1'b1;
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    assign btn_rise = stable_q & ~stable_prev_q;
    assign adv = ~bus.hold &
                 (btn_rise | (bus.auto_mode & (dwell_q == DWW'(DWELL_CYCLES - 1))));

    function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] v, input int start);
        logic found;
        int   idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (start + k) % NUM_SRC;
            if (!found && v[idx]) begin
                rr_pick = SW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    assign nxt_sel = rr_pick(bus.src_valid, int'(src_sel_q) + 1);

    // Dropout of the shown source outranks both hold and adv.
    always_comb begin
        state_d   = state_q;
        src_sel_d = src_sel_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.src_valid) begin
                    state_d   = SHOW_UPPER;
                    src_sel_d = rr_pick(bus.src_valid, 0);
                    load      = 1'b1;
                end
            end
            default: begin
                if (!bus.src_valid[src_sel_q]) begin
                    if (|bus.src_valid) begin
                        state_d   = SHOW_UPPER;
                        src_sel_d = nxt_sel;
                        load      = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (adv) begin
                    if (state_q == SHOW_UPPER) begin
                        state_d = SHOW_LOWER;
                    end else begin
                        state_d   = SHOW_UPPER;
                        src_sel_d = nxt_sel;
                        load      = 1'b1;
                    end
                end
            end
        endcase
    end

    assign changed = (state_d != state_q) || (src_sel_d != src_sel_q);

    always_comb begin
        dwell_d = dwell_q;
        if (changed || !bus.auto_mode || state_q == IDLE) begin
            dwell_d = '0;
        end else if (!bus.hold) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            src_sel_q   <= '0;
            disp_word_q <= '0;
            lower_q     <= 1'b0;
            blank_q     <= 1'b1;
            dwell_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_sel_q <= src_sel_d;
            dwell_q   <= dwell_d;
            lower_q   <= (state_d == SHOW_LOWER);
            blank_q   <= (state_d == IDLE);
            if (load) begin
                disp_word_q <= bus.src_word[32*int'(src_sel_d) +: 32];
            end
        end
    end

    assign bus.disp_word   = disp_word_q;
    assign bus.lower_bytes = lower_q;
    assign bus.src_sel     = src_sel_q;
    assign bus.blank       = blank_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench for disp_scheduler: expected output changes are queued by
// the stimulus and checked by a monitor whenever the DUT outputs change.
module tb_disp_scheduler;
    localparam int NS = 3;
    localparam int W  = 54;  // {tmode[1:0], tval[15:0], blank, sel[1:0], lower, word[31:0]}

    logic clk;
    logic rst;

    disp_scheduler_if #(.NUM_SRC(NS)) bus ();

    disp_scheduler #(
        .NUM_SRC(NS),
        .DWELL_CYCLES(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mark   = 0;
    int gap    = 0;
    int n_evt  = 0;
    bit mon_en = 1'b0;
    logic [35:0] prev_t;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic b, input logic [1:0] s, input logic l,
                        input logic [31:0] w, input logic [1:0] tm, input int tv);
        exp_q.push_back({tm, 16'(tv), b, s, l, w});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drain(input int max_cyc);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max_cyc) begin
            step(1);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d expected changes never seen, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [35:0]  cur_t;
        logic [W-1:0] e;
        if (mon_en) begin
            cur_t = {bus.blank, bus.src_sel, bus.lower_bytes, bus.disp_word};
            gap   = gap + 1;
            if (cur_t !== prev_t) begin
                n_evt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_change #%0d: got %h expected no change from %h",
                             n_evt, cur_t, prev_t);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (cur_t !== e[35:0]) begin
                        n_fail++;
                        $display("FAIL output_tuple #%0d: got %h expected %h", n_evt, cur_t, e[35:0]);
                    end
                    if (e[53:52] == 2'd1) begin
                        n_cmp++;
                        if (gap != int'(e[51:36])) begin
                            n_fail++;
                            $display("FAIL phase_length #%0d: got %0d expected %0d", n_evt, gap, e[51:36]);
                        end
                    end else if (e[53:52] == 2'd2) begin
                        n_cmp++;
                        if (cyc - mark != int'(e[51:36])) begin
                            n_fail++;
                            $display("FAIL latency #%0d: got %0d expected %0d", n_evt, cyc - mark, e[51:36]);
                        end
                    end
                end
                prev_t = cur_t;
                gap    = 0;
            end
        end
    end

    initial begin
        rst           = 1'b0;
        bus.src_word  = '0;
        bus.src_valid = '0;
        bus.btn_next  = 1'b0;
        bus.auto_mode = 1'b0;
        bus.hold      = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_blank", 32'(bus.blank), 32'd1);
        check("reset_sel", 32'(bus.src_sel), 32'd0);
        check("reset_lower", 32'(bus.lower_bytes), 32'd0);
        check("reset_word", bus.disp_word, 32'd0);
        prev_t = {1'b1, 2'd0, 1'b0, 32'd0};
        mon_en = 1'b1;

        // 1: auto rotation through all three sources
        bus.src_word  = {32'h55556666, 32'h33334444, 32'h11112222};
        bus.src_valid = 3'b111;
        bus.auto_mode = 1'b1;
        @(negedge clk);
        #1;
        push(1'b0, 2'd0, 1'b0, 32'h11112222, 2'd2, 1);
        push(1'b0, 2'd0, 1'b1, 32'h11112222, 2'd1, 8);
        push(1'b0, 2'd1, 1'b0, 32'h33334444, 2'd1, 8);
        push(1'b0, 2'd1, 1'b1, 32'h33334444, 2'd1, 8);
        push(1'b0, 2'd2, 1'b0, 32'h55556666, 2'd1, 8);
        push(1'b0, 2'd2, 1'b1, 32'h55556666, 2'd1, 8);
        push(1'b0, 2'd0, 1'b0, 32'h11112222, 2'd1, 8);
        mark = cyc;
        rst  = 1'b0;
        drain(200);

        // 2+3: skip index 1; word change during upper phase stays invisible
        bus.src_word[31:0] = 32'hDEADBEEF;
        bus.src_valid      = 3'b101;
        push(1'b0, 2'd0, 1'b1, 32'h11112222, 2'd1, 8);
        push(1'b0, 2'd2, 1'b0, 32'h55556666, 2'd1, 8);
        push(1'b0, 2'd2, 1'b1, 32'h55556666, 2'd1, 8);
        push(1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 2'd1, 8);
        push(1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 2'd1, 8);
        push(1'b0, 2'd2, 1'b0, 32'h55556666, 2'd1, 8);
        drain(200);

        // 4: manual mode, short glitches then one clean press
        bus.auto_mode = 1'b0;
        repeat (2) begin
            bus.btn_next = 1'b1;
            step(3);
            bus.btn_next = 1'b0;
            step(6);
        end
        mark = cyc;
        push(1'b0, 2'd2, 1'b1, 32'h55556666, 2'd2, 7);
        bus.btn_next = 1'b1;
        step(10);
        bus.btn_next = 1'b0;
        step(20);
        drain(5);

        // 5: hold swallows timer and button, dropout still moves on
        bus.auto_mode = 1'b1;
        bus.hold      = 1'b1;
        bus.btn_next  = 1'b1;
        step(10);
        bus.btn_next = 1'b0;
        step(40);
        mark = cyc;
        bus.src_valid = 3'b001;
        push(1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 2'd2, 1);
        drain(20);
        step(5);

        // 6: empty, recover, then async reset during lower phase
        mark = cyc;
        bus.src_valid = 3'b000;
        push(1'b1, 2'd0, 1'b0, 32'hDEADBEEF, 2'd2, 1);
        drain(20);
        step(3);
        mark = cyc;
        bus.src_valid = 3'b111;
        bus.hold      = 1'b0;
        push(1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 2'd2, 1);
        push(1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 2'd1, 8);
        drain(50);
        step(3);
        push(1'b1, 2'd0, 1'b0, 32'd0, 2'd0, 0);
        rst = 1'b1;
        #1;
        check("async_rst_blank", 32'(bus.blank), 32'd1);
        check("async_rst_sel", 32'(bus.src_sel), 32'd0);
        check("async_rst_lower", 32'(bus.lower_bytes), 32'd0);
        check("async_rst_word", bus.disp_word, 32'd0);
        check("async_rst_state", 32'(bus.dbg_state), 32'd0);
        drain(5);
        step(2);
        mark = cyc;
        rst  = 1'b0;
        push(1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 2'd2, 1);
        drain(20);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
